// File: rtl/button_debounce_pulse_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and level decode.
package button_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // Debounced level is "pressed" while the accepted state is pressed, even mid release check.
  function automatic logic level_of(input state_t st);
    return (st == PRESSED) || (st == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin; reset value is parameterised
// so the chain can idle at the pin's inactive level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RST_VAL;
      q_reg    <= RST_VAL;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/button_debounce_pulse.sv
// Button synchroniser/debouncer producing a clean level, press/release strobes and a press count.
// Optional auto-repeat of press_pulse while held is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam logic                 IDLE_PIN = (ACTIVE_LOW != 0);
  localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic sync_q;
  logic s;

  sync_2ff #(.RST_VAL(IDLE_PIN)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (sync_q)
  );

  assign s = sync_q ^ IDLE_PIN;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 btn_level_reg;
  logic                 press_pulse_reg;
  logic                 release_pulse_reg;
  logic [7:0]           press_count_reg;
  logic                 rep_fire;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] REP_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  logic [CNT_WIDTH-1:0] rep_cnt_reg;
  logic                 rep_periodic_reg;

  assign rep_fire = (state_reg == PRESSED) && s &&
                    (rep_cnt_reg == (rep_periodic_reg ? REP_PERIOD_LAST : REP_DELAY_LAST));

  // Held at zero outside a stable PRESSED, so every entry restarts the initial delay phase.
  always_ff @(posedge clk) begin
    if (rst || (state_reg != PRESSED) || !s) begin
      rep_cnt_reg      <= '0;
      rep_periodic_reg <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt_reg      <= '0;
      rep_periodic_reg <= 1'b1;
    end else begin
      rep_cnt_reg      <= rep_cnt_reg + 1'b1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= RELEASED;
      cnt_reg           <= '0;
      btn_level_reg     <= 1'b0;
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      press_count_reg   <= '0;
    end else begin
      press_pulse_reg   <= 1'b0;
      release_pulse_reg <= 1'b0;
      case (state_reg)
        RELEASED: begin
          if (s) begin
            state_reg <= PRESS_CHK;
            cnt_reg   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!s) begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_reg       <= PRESSED;
            cnt_reg         <= '0;
            btn_level_reg   <= level_of(PRESSED);
            press_pulse_reg <= 1'b1;
            press_count_reg <= press_count_reg + 8'd1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_reg <= RELEASE_CHK;
            cnt_reg   <= '0;
          end else if (rep_fire) begin
            press_pulse_reg <= 1'b1;
            press_count_reg <= press_count_reg + 8'd1;
          end
        end
        RELEASE_CHK: begin
          if (s) begin
            state_reg <= PRESSED;
            cnt_reg   <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_reg         <= RELEASED;
            cnt_reg           <= '0;
            btn_level_reg     <= level_of(RELEASED);
            release_pulse_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= RELEASED;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign btn_level     = btn_level_reg;
  assign press_pulse   = press_pulse_reg;
  assign release_pulse = release_pulse_reg;
  assign press_count   = press_count_reg;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse (DEBOUNCE_CYCLES=8), active-high and active-low instances.
module tb_button_debounce_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       btn_n = 1'b1;

  logic       a_level, a_press, a_release;
  logic [7:0] a_count;
  logic       b_level, b_press, b_release;
  logic [7:0] b_count;

  int errors = 0;
  int checks = 0;
  int press_seen = 0;
  int release_seen = 0;
  int both_seen = 0;

  always #5 clk = ~clk;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(8), .CNT_WIDTH(20), .ACTIVE_LOW(0),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(a_level), .press_pulse(a_press),
    .release_pulse(a_release), .press_count(a_count)
  );

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(8), .CNT_WIDTH(20), .ACTIVE_LOW(1),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_n),
    .btn_level(b_level), .press_pulse(b_press),
    .release_pulse(b_release), .press_count(b_count)
  );

  always @(posedge clk) begin
    if (a_press)              press_seen   <= press_seen + 1;
    if (a_release)            release_seen <= release_seen + 1;
    if (a_press && a_release) both_seen    <= both_seen + 1;
  end

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end else begin
      $display("ok   %s: %0d", tag, act);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input already driven; next posedge is the first sampling edge k. Strobe lives after edge k+10.
  task automatic expect_pulse(input string tag, input bit rel);
    tick(10);
    check({tag, "_early"}, rel ? int'(a_release) : int'(a_press), 0);
    tick(1);
    check({tag, "_hit"}, rel ? int'(a_release) : int'(a_press), 1);
    check({tag, "_level"}, int'(a_level), rel ? 0 : 1);
    tick(1);
    check({tag, "_single"}, rel ? int'(a_release) : int'(a_press), 0);
  endtask

  initial begin
    int p0;
    int r0;

    tick(3);
    check("rst_level", int'(a_level), 0);
    check("rst_press", int'(a_press), 0);
    check("rst_release", int'(a_release), 0);
    check("rst_count", int'(a_count), 0);
    check("rst_b_level", int'(b_level), 0);
    rst = 1'b0;
    tick(2);

    // clean press and release
    btn = 1'b1;
    expect_pulse("press", 1'b0);
    check("press_count1", int'(a_count), 1);
    tick(5);
    btn = 1'b0;
    expect_pulse("release", 1'b1);
    check("release_count1", int'(a_count), 1);
    tick(5);

    // bounce: 1,0,1,0 at 3-cycle intervals, then held
    p0 = press_seen;
    btn = 1'b1; tick(3);
    btn = 1'b0; tick(3);
    btn = 1'b1; tick(3);
    btn = 1'b0; tick(3);
    btn = 1'b1;
    expect_pulse("bounce", 1'b0);
    check("bounce_npulse", press_seen - p0, 1);
    check("bounce_count", int'(a_count), 2);
    btn = 1'b0;
    tick(14);

    // glitches of 7 and 8 samples are both too short to be accepted
    p0 = press_seen;
    btn = 1'b1; tick(7);
    btn = 1'b0; tick(20);
    check("glitch7_npulse", press_seen - p0, 0);
    check("glitch7_level", int'(a_level), 0);
    btn = 1'b1; tick(8);
    btn = 1'b0; tick(20);
    check("glitch8_npulse", press_seen - p0, 0);
    check("glitch8_level", int'(a_level), 0);

    // reset while pressed
    btn = 1'b1;
    tick(12);
    check("pre_rst_level", int'(a_level), 1);
    r0 = release_seen;
    rst = 1'b1;
    tick(1);
    check("midrst_level", int'(a_level), 0);
    check("midrst_press", int'(a_press), 0);
    check("midrst_release", int'(a_release), 0);
    check("midrst_count", int'(a_count), 0);
    rst = 1'b0;
    expect_pulse("post_rst_press", 1'b0);
    check("post_rst_count", int'(a_count), 1);
    check("post_rst_no_release", release_seen - r0, 0);
    btn = 1'b0;
    tick(14);

    // 256 press/release cycles wrap the counter
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(2);
    p0 = press_seen;
    r0 = release_seen;
    for (int i = 0; i < 256; i++) begin
      btn = 1'b1; tick(12);
      if (i == 254) check("wrap_count255", int'(a_count), 255);
      btn = 1'b0; tick(12);
    end
    check("wrap_npress", press_seen - p0, 256);
    check("wrap_nrelease", release_seen - r0, 256);
    check("wrap_count", int'(a_count), 0);
    check("wrap_level", int'(a_level), 0);

    // active-low instance: idle high, press by driving low
    check("al_idle_level", int'(b_level), 0);
    check("al_idle_count", int'(b_count), 0);
    btn_n = 1'b0;
    tick(10);
    check("al_press_early", int'(b_press), 0);
    tick(1);
    check("al_press_hit", int'(b_press), 1);
    check("al_level", int'(b_level), 1);
    tick(1);
    check("al_press_single", int'(b_press), 0);
    check("al_count", int'(b_count), 1);

    check("never_both", both_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
